p_hit_ray_t: RTL and testbench

- First stage of the ray/triangle hit-point pipeline.
- For each queued ray (origin, dir), computes the ray parameter t = dot(n1, v0 − origin) / dot(n2, dir) in signed fixed point, using one triangle held on static inputs.
- Rays enter through two lock-stepped input FIFOs: FIFO0 holds origin, FIFO1 holds dir.
- Results leave through a first-word-fall-through output FIFO.
- Downstream stages read t to build the hit point.

---
 rtl/p_hit_ray_t_if.sv | 21 ++
 rtl/p_hit_ray_t.sv | 144 ++++++++++++++
 tb/tb_p_hit_ray_t.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/p_hit_ray_t_if.sv
// p_hit_ray_t_if: ray queue, static triangle and result FIFO signals of the t-parameter stage.
interface p_hit_ray_t_if;
    logic signed [31:0] tri_normal_1 [3];
    logic signed [31:0] tri_normal_2 [3];
    logic signed [31:0] v0 [3];
    logic signed [31:0] origin [3];
    logic signed [31:0] dir [3];
    logic [1:0]         in_wr_en;
    logic [1:0]         in_full;
    logic signed [31:0] out;
    logic               out_rd_en;
    logic               out_empty;
    modport master (
        output tri_normal_1, tri_normal_2, v0, origin, dir, in_wr_en, out_rd_en,
        input  in_full, out, out_empty
    );
    modport slave (
        input  tri_normal_1, tri_normal_2, v0, origin, dir, in_wr_en, out_rd_en,
        output in_full, out, out_empty
    );
endinterface

// File: rtl/p_hit_ray_t.sv
// p_hit_ray_t: computes t = dot(n1, v0 - origin) / dot(n2, dir) per queued ray in signed fixed point.
module p_hit_ray_t #(
    parameter int Q_BITS     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input logic          clock,
    input logic          reset,
    p_hit_ray_t_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, DOT1, DOT2, DIV, PUSH} state_t;
    state_t r_state, w_next;
    logic [95:0] r_in_mem [2][FIFO_DEPTH];
    logic [AW:0] r_in_wp [2];
    logic [AW:0] r_in_rp [2];
    logic [95:0] w_in_data [2];
    logic [1:0]  w_in_full, w_in_empty, w_in_wr;
    logic [31:0] r_out_mem [FIFO_DEPTH];
    logic [AW:0] r_out_wp, r_out_rp;
    logic        w_out_full, w_out_empty, w_out_rd, w_pop, w_push;
    logic signed [31:0] r_n1 [3];
    logic signed [31:0] r_n2 [3];
    logic signed [31:0] r_v0 [3];
    logic signed [31:0] r_org [3];
    logic signed [31:0] r_dir [3];
    logic signed [31:0] r_d [3];
    logic signed [63:0] w_pn [3];
    logic signed [63:0] w_pd [3];
    logic signed [65:0] w_num, w_den;
    logic [65:0]        w_num_mag, w_den_mag, r_den_mag, r_rem;
    logic [65+Q_BITS:0] w_dvd_full;
    logic [63:0]        r_dvd, r_quo;
    logic [66:0]        w_rem_sh, w_diff;
    logic               w_qbit, w_big, r_neg, r_ovf, r_den_zero;
    logic [5:0]         r_cnt;
    logic [31:0]        w_res;
    always_comb begin
        w_in_data[0] = {bus.origin[2], bus.origin[1], bus.origin[0]};
        w_in_data[1] = {bus.dir[2], bus.dir[1], bus.dir[0]};
        for (int k = 0; k < 2; k++) begin
            w_in_full[k]  = (r_in_wp[k] - r_in_rp[k]) == (AW+1)'(FIFO_DEPTH);
            w_in_empty[k] = r_in_wp[k] == r_in_rp[k];
            w_in_wr[k]    = bus.in_wr_en[k] && !w_in_full[k];
        end
    end
    assign w_out_full  = (r_out_wp - r_out_rp) == (AW+1)'(FIFO_DEPTH);
    assign w_out_empty = r_out_wp == r_out_rp;
    assign w_out_rd    = bus.out_rd_en && !w_out_empty;
    assign bus.in_full   = w_in_full;
    assign bus.out_empty = w_out_empty;
    assign bus.out       = w_out_empty ? '0 : r_out_mem[r_out_rp[AW-1:0]];
    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_push = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !(|w_in_empty);
                w_next = w_pop ? DOT1 : IDLE;
            end
            DOT1: w_next = DOT2;
            DOT2: w_next = DIV;
            DIV:  w_next = (r_den_zero || r_ovf || r_cnt == 6'd63) ? PUSH : DIV;
            PUSH: begin
                w_push = !w_out_full;
                w_next = w_out_full ? PUSH : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                r_in_wp[k] <= '0;
                r_in_rp[k] <= '0;
            end
            r_out_wp <= '0;
            r_out_rp <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_in_wp[k] <= r_in_wp[k] + (AW+1)'(w_in_wr[k]);
                r_in_rp[k] <= r_in_rp[k] + (AW+1)'(w_pop);
            end
            r_out_wp <= r_out_wp + (AW+1)'(w_push);
            r_out_rp <= r_out_rp + (AW+1)'(w_out_rd);
        end
    end
    always_ff @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            if (w_in_wr[k]) r_in_mem[k][r_in_wp[k][AW-1:0]] <= w_in_data[k];
        if (w_push) r_out_mem[r_out_wp[AW-1:0]] <= w_res;
    end
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_pn[i] = 64'(r_n1[i]) * 64'(r_d[i]);
            w_pd[i] = 64'(r_n2[i]) * 64'(r_dir[i]);
        end
        w_num      = (66'(w_pn[0]) + 66'(w_pn[1]) + 66'(w_pn[2])) >>> Q_BITS;
        w_den      = (66'(w_pd[0]) + 66'(w_pd[1]) + 66'(w_pd[2])) >>> Q_BITS;
        w_num_mag  = w_num[65] ? -w_num : w_num;
        w_den_mag  = w_den[65] ? -w_den : w_den;
        w_dvd_full = {w_num_mag, {Q_BITS{1'b0}}};
        w_rem_sh   = {r_rem, r_dvd[63]};
        w_diff     = w_rem_sh - {1'b0, r_den_mag};
        w_qbit     = !w_diff[66];
        w_big      = r_ovf || (|r_quo[63:31]);
        w_res      = r_den_zero ? 32'h7FFF_FFFF :
                     w_big      ? (r_neg ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                     (r_neg ? -r_quo[31:0] : r_quo[31:0]);
    end
    // Quotient bits above 63 are pre-checked via the dividend's top slice, so 64 steps suffice.
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_n1 <= bus.tri_normal_1;
            r_n2 <= bus.tri_normal_2;
            r_v0 <= bus.v0;
            for (int i = 0; i < 3; i++) begin
                r_org[i] <= r_in_mem[0][r_in_rp[0][AW-1:0]][32*i +: 32];
                r_dir[i] <= r_in_mem[1][r_in_rp[1][AW-1:0]][32*i +: 32];
            end
        end
        if (r_state == DOT1)
            for (int i = 0; i < 3; i++) r_d[i] <= r_v0[i] - r_org[i];
        if (r_state == DOT2) begin
            r_den_mag  <= w_den_mag;
            r_dvd      <= w_dvd_full[63:0];
            r_rem      <= 66'(w_dvd_full[65+Q_BITS:64]);
            r_ovf      <= 66'(w_dvd_full[65+Q_BITS:64]) >= w_den_mag;
            r_den_zero <= w_den == '0;
            r_neg      <= w_num[65] ^ w_den[65];
            r_cnt      <= '0;
        end
        if (r_state == DIV) begin
            r_rem <= w_qbit ? w_diff[65:0] : w_rem_sh[65:0];
            r_dvd <= r_dvd << 1;
            r_quo <= {r_quo[62:0], w_qbit};
            r_cnt <= r_cnt + 6'd1;
        end
    end
endmodule

// File: tb/tb_p_hit_ray_t.sv
// tb_p_hit_ray_t: scoreboard bench for the ray parameter stage.
module tb_p_hit_ray_t;
    localparam int Q = 16;
    localparam logic [31:0] ONE = 32'h0001_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    always #5 clk = ~clk;
    p_hit_ray_t_if bus ();
    p_hit_ray_t #(.Q_BITS(Q), .FIFO_DEPTH(16)) dut (.clock(clk), .reset(rst_n), .bus(bus));

    function automatic logic [31:0] model_t(input logic signed [31:0] n1 [3], input logic signed [31:0] n2 [3],
                                            input logic signed [31:0] v [3], input logic signed [31:0] o [3],
                                            input logic signed [31:0] dr [3]);
        logic signed [127:0] num, den, q;
        logic signed [31:0] d;
        num = '0;
        den = '0;
        for (int i = 0; i < 3; i++) begin
            d = v[i] - o[i];
            num = num + 128'(d) * 128'(n1[i]);
            den = den + 128'(dr[i]) * 128'(n2[i]);
        end
        num = num >>> Q;
        den = den >>> Q;
        if (den == 0) return 32'h7FFF_FFFF;
        q = (num <<< Q) / den;
        if (q > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (q < -128'sh8000_0000) return 32'h8000_0000;
        return q[31:0];
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] u;
        u = $urandom_range(0, 32'h0010_0000);
        return u - 32'h0008_0000;
    endfunction

    task automatic set_static(input logic [31:0] nx, ny, nz, vx, vy, vz);
        bus.tri_normal_1 = '{nx, ny, nz};
        bus.tri_normal_2 = '{nx, ny, nz};
        bus.v0 = '{vx, vy, vz};
    endtask

    task automatic push_ray(input logic [31:0] ox, oy, oz, dx, dy, dz, input logic [31:0] e,
                            input bit track, output bit acc);
        acc = (bus.in_full == 2'b00);
        bus.origin = '{ox, oy, oz};
        bus.dir = '{dx, dy, dz};
        bus.in_wr_en = 2'b11;
        if (acc && track) exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_wr_en = 2'b00;
    endtask

    task automatic drain(input string name, input int n, input int budget);
        int got = 0;
        int cyc = 0;
        logic [31:0] e;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (!bus.out_empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected: got %h required no output", name, bus.out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e) begin
                        failures++;
                        $display("FAIL %s[%0d]: got %h required %h", name, got, bus.out, e);
                    end
                end
                bus.out_rd_en = 1'b1;
                got++;
            end else bus.out_rd_en = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.out_rd_en = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s count: got %0d results required %0d", name, got, n);
        end
    endtask

    task automatic push_one(input string name, input logic [31:0] ox, oy, oz, dx, dy, dz, input logic [31:0] e);
        bit acc;
        @(negedge clk);
        push_ray(ox, oy, oz, dx, dy, dz, e, 1'b1, acc);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL %s accept: got in_full=%b required 00", name, bus.in_full);
        end
        drain(name, 1, 80);
    endtask

    task automatic test_reset();
        bus.in_wr_en = 2'b00;
        bus.out_rd_en = 1'b0;
        set_static(0, 0, 0, 0, 0, 0);
        bus.origin = '{0, 0, 0};
        bus.dir = '{0, 0, 0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (bus.out_empty !== 1'b1) begin failures++; $display("FAIL reset out_empty: got %b required 1", bus.out_empty); end
        if (bus.in_full !== 2'b00) begin failures++; $display("FAIL reset in_full: got %b required 00", bus.in_full); end
        if (bus.out !== 32'h0) begin failures++; $display("FAIL reset out: got %h required 00000000", bus.out); end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (bus.out_empty !== 1'b1) begin failures++; $display("FAIL idle out_empty: got %b required 1", bus.out_empty); end
    endtask

    task automatic test_basic();
        set_static(0, 0, ONE, 0, 0, 5 * ONE);
        push_one("basic", 0, 0, 0, 0, 0, ONE, 32'h0005_0000);
    endtask

    task automatic test_fraction();
        push_one("frac", 0, 0, 0, 0, 0, 2 * ONE, 32'h0002_8000);
        push_one("negative", 0, 0, 10 * ONE, 0, 0, ONE, 32'hFFFB_0000);
        set_static(0, 0, ONE, 0, 0, ONE);
        push_one("third", 0, 0, 0, 0, 0, 3 * ONE, 32'h0000_5555);
        push_one("neg_third", 0, 0, 2 * ONE, 0, 0, 3 * ONE, 32'hFFFF_AAAB);
    endtask

    task automatic test_parallel();
        set_static(0, 0, ONE, 0, 0, 5 * ONE);
        push_one("parallel", 0, 0, 0, ONE, 0, 0, 32'h7FFF_FFFF);
    endtask

    task automatic test_saturate();
        set_static(0, 0, ONE, 0, 0, 32'h7FFF_0000);
        push_one("sat_pos", 0, 0, 0, 0, 0, 32'h0000_0001, 32'h7FFF_FFFF);
        push_one("sat_neg", 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h8000_0000);
    endtask

    task automatic test_random();
        logic signed [31:0] n1 [3];
        logic signed [31:0] n2 [3];
        logic signed [31:0] v [3];
        logic signed [31:0] o [3];
        logic signed [31:0] dr [3];
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                n1[i] = rnd();
                n2[i] = (r < 3) ? n1[i] : rnd();
                v[i] = rnd();
                o[i] = rnd();
                dr[i] = rnd();
            end
            bus.tri_normal_1 = n1;
            bus.tri_normal_2 = n2;
            bus.v0 = v;
            push_one("random", o[0], o[1], o[2], dr[0], dr[1], dr[2], model_t(n1, n2, v, o, dr));
        end
    endtask

    task automatic test_back_to_back();
        int k = 1;
        int guard = 0;
        bit acc;
        set_static(0, 0, ONE, 0, 0, 0);
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (k <= 40 && bus.in_full == 2'b00) begin
                push_ray(0, 0, 32'(-k * 65536), 0, 0, ONE, 32'(k * 65536), 1'b1, acc);
                k++;
            end
        end
        checks += 3;
        if (bus.in_full !== 2'b11) begin failures++; $display("FAIL stream full: got %b required 11", bus.in_full); end
        if (bus.out_empty !== 1'b0) begin failures++; $display("FAIL stream out_empty: got %b required 0", bus.out_empty); end
        if (exp_q.size() != 33) begin failures++; $display("FAIL stream accepted: got %0d required 33", exp_q.size()); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (bus.in_full !== 2'b11) begin failures++; $display("FAIL junk full: got %b required 11", bus.in_full); end
            push_ray(0, 0, 32'(-999 * 65536), 0, 0, ONE, 32'(999 * 65536), 1'b0, acc);
        end
        fork
            while (k <= 40 && guard < 6000) begin
                @(negedge clk);
                guard++;
                if (bus.in_full == 2'b00) begin
                    push_ray(0, 0, 32'(-k * 65536), 0, 0, ONE, 32'(k * 65536), 1'b1, acc);
                    k++;
                end
            end
            drain("stream", 40, 6000);
        join
        repeat (150) @(negedge clk);
        checks += 2;
        if (bus.out_empty !== 1'b1) begin failures++; $display("FAIL stream extra: got out_empty=%b required 1", bus.out_empty); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL stream leftover: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_div();
        bit acc;
        set_static(0, 0, ONE, 0, 0, 5 * ONE);
        @(negedge clk);
        push_ray(0, 0, 0, 0, 0, ONE, 32'h0005_0000, 1'b0, acc);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        checks += 2;
        if (bus.out_empty !== 1'b1) begin failures++; $display("FAIL reset_div out_empty: got %b required 1", bus.out_empty); end
        if (bus.in_full !== 2'b00) begin failures++; $display("FAIL reset_div in_full: got %b required 00", bus.in_full); end
        push_one("after_reset", 0, 0, 0, 0, 0, ONE, 32'h0005_0000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_parallel();
        test_saturate();
        test_random();
        test_back_to_back();
        test_reset_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
